trail_backtrack_ctrl: RTL

- Sequencer that owns the push/pop port of the DPLL trail (trace) stack.
- Arbitrates trail pushes between the decision unit (D entries) and BCP (F entries).
- On a conflict, it pops the trail, unassigns forced variables, and flips the most recent decision, which it re-pushes as a forced entry.
- If the trail empties without finding a decision, it reports UNSAT. Sits between decider/BCP and the trail stack and the variable-assignment table.

---
 rtl/trail_backtrack_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/trail_backtrack_ctrl.sv
// trail_backtrack_ctrl: sequencer that owns the trail stack push/pop port.
// It arbitrates trail pushes between the decider (D entries) and BCP
// (F entries). On a conflict it unwinds the trail, unassigning forced
// variables, then flips the most recent decision and re-pushes it as forced.
// It reports UNSAT if the trail empties before a decision is found.
// Optional feature macro: BT_STATS_EN adds saturating bt_count/pop_count
// statistics. Without it both counters are tied to zero.
module trail_backtrack_ctrl #(
  parameter int VAR_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_req,
  input  logic [VAR_W-1:0] dec_var,
  input  logic             dec_val,
  output logic             dec_ack,
  input  logic             imp_req,
  input  logic [VAR_W-1:0] imp_var,
  input  logic             imp_val,
  output logic             imp_ack,
  input  logic             conflict,
  output logic             tt_push,
  output logic             tt_pop,
  output logic             tt_type,
  output logic             tt_val,
  output logic [VAR_W-1:0] tt_var,
  input  logic             tt_done,
  input  logic             tt_empty,
  input  logic             tt_type_in,
  input  logic             tt_val_in,
  input  logic [VAR_W-1:0] tt_var_in,
  output logic             ua_valid,
  output logic [VAR_W-1:0] ua_var,
  output logic             asg_valid,
  output logic [VAR_W-1:0] asg_var,
  output logic             asg_val,
  output logic             busy,
  output logic             bt_done,
  output logic             unsat,
  output logic [CNT_W-1:0] bt_count,
  output logic [CNT_W-1:0] pop_count
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WAIT,
    POP_WAIT,
    FLIP_WAIT,
    UNSAT
  } state_t;

  state_t state;

  // busy comes straight from the state register, so it has no input path
  assign busy = (state != IDLE);

  // Main sequencer. Every strobe and pulse is registered and lasts one cycle.
  // Push data is held until the trail reports completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dec_ack   <= 1'b0;
      imp_ack   <= 1'b0;
      tt_push   <= 1'b0;
      tt_pop    <= 1'b0;
      tt_type   <= 1'b0;
      tt_val    <= 1'b0;
      tt_var    <= '0;
      ua_valid  <= 1'b0;
      ua_var    <= '0;
      asg_valid <= 1'b0;
      asg_var   <= '0;
      asg_val   <= 1'b0;
      bt_done   <= 1'b0;
      unsat     <= 1'b0;
    end else begin
      dec_ack   <= 1'b0;
      imp_ack   <= 1'b0;
      tt_push   <= 1'b0;
      tt_pop    <= 1'b0;
      ua_valid  <= 1'b0;
      asg_valid <= 1'b0;
      bt_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (conflict) begin
            tt_pop <= 1'b1;
            state  <= POP_WAIT;
          end else if (imp_req) begin
            imp_ack <= 1'b1;
            tt_push <= 1'b1;
            tt_type <= 1'b1;
            tt_val  <= imp_val;
            tt_var  <= imp_var;
            state   <= PUSH_WAIT;
          end else if (dec_req) begin
            dec_ack <= 1'b1;
            tt_push <= 1'b1;
            tt_type <= 1'b0;
            tt_val  <= dec_val;
            tt_var  <= dec_var;
            state   <= PUSH_WAIT;
          end
        end
        PUSH_WAIT: begin
          if (tt_done) begin
            state <= IDLE;
          end
        end
        POP_WAIT: begin
          if (tt_done) begin
            if (tt_empty) begin
              unsat <= 1'b1;
              state <= UNSAT;
            end else if (tt_type_in) begin
              ua_valid <= 1'b1;
              ua_var   <= tt_var_in;
              tt_pop   <= 1'b1;
            end else begin
              asg_valid <= 1'b1;
              asg_var   <= tt_var_in;
              asg_val   <= ~tt_val_in;
              tt_push   <= 1'b1;
              tt_type   <= 1'b1;
              tt_val    <= ~tt_val_in;
              tt_var    <= tt_var_in;
              state     <= FLIP_WAIT;
            end
          end
        end
        FLIP_WAIT: begin
          if (tt_done) begin
            bt_done <= 1'b1;
            state   <= IDLE;
          end
        end
        UNSAT: begin
          state <= UNSAT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BT_STATS_EN
  // Saturating statistics: completed backtracks and non-empty pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bt_count  <= '0;
      pop_count <= '0;
    end else begin
      if (state == FLIP_WAIT && tt_done && bt_count != {CNT_W{1'b1}}) begin
        bt_count <= bt_count + CNT_W'(1);
      end
      if (state == POP_WAIT && tt_done && !tt_empty &&
          pop_count != {CNT_W{1'b1}}) begin
        pop_count <= pop_count + CNT_W'(1);
      end
    end
  end
`else
  assign bt_count  = '0;
  assign pop_count = '0;
`endif

endmodule
